// File: rtl/arduino_cmd_receiver.sv
// UART command receiver for the Arduino note/menu controller: 8N1 (or 8E1 with
// RX_PARITY_EN defined) framing, decodes menu pulses and held one-hot note keys.
module arduino_cmd_receiver #(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned HOLD_CYCLES = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [12:0] botoes,
    output logic        right_arrow_pressed,
    output logic        left_arrow_pressed,
    output logic        enter_pressed,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        parity_err
);

    localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BAUD;
    localparam int unsigned HALF       = BIT_CYCLES / 2;
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned NOTE_COUNT = 13;
    localparam logic [7:0]  NOTE_FIRST = 8'h61;
    localparam logic [7:0]  NOTE_LAST  = 8'h6D;
    localparam logic [7:0]  CODE_RIGHT = 8'h52;
    localparam logic [7:0]  CODE_LEFT  = 8'h4C;
    localparam logic [7:0]  CODE_ENTER = 8'h45;
    localparam logic [7:0]  CODE_CR    = 8'h0D;

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        bit_cnt, bit_next;
    logic [7:0]        shift, shift_next;
    logic              rx_s1, rx_s2, rx_prev;
    logic [1:0]        sync_ok;
    logic              armed;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept_c, frame_err_c, parity_err_c;
    logic              par_ok_c, bit_done_c, is_note_c;
    logic [3:0]        note_idx_c;

`ifdef RX_PARITY_EN
    logic par_bad, par_next;
    assign par_ok_c = ~par_bad;
`else
    assign par_ok_c = 1'b1;
`endif

    // Two-flop synchronizer plus edge history; sync_ok marks when rx_s2 carries real line data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            sync_ok <= {sync_ok[0], 1'b1};
            if (sync_ok[1] && rx_s2)
                armed <= 1'b1;
        end
    end

    // A line held low through reset must be seen high before any start bit counts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset)
            par_bad <= 1'b0;
        else
            par_bad <= par_next;
    end
`endif

    assign bit_done_c = (cnt == CNT_W'(BIT_CYCLES - 1));

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_next     = bit_cnt;
        shift_next   = shift;
        accept_c     = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
`ifdef RX_PARITY_EN
        par_next     = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (armed && rx_prev && !rx_s2)
                    state_next = START;
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_next   = '0;
                    state_next = rx_s2 ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    cnt_next   = '0;
                    shift_next = {rx_s2, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_next = '0;
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_done_c) begin
                    cnt_next   = '0;
                    par_next   = rx_s2 ^ (^shift);
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done_c) begin
                    cnt_next = '0;
`ifdef RX_PARITY_EN
                    parity_err_c = par_bad;
`endif
                    if (rx_s2) begin
                        accept_c   = par_ok_c;
                        state_next = IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_next  = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s2)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign is_note_c  = (shift >= NOTE_FIRST) && (shift <= NOTE_LAST);
    assign note_idx_c = 4'(shift - NOTE_FIRST);

    // Byte delivery, menu decode and note-key hold timer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_byte             <= '0;
            byte_valid          <= 1'b0;
            frame_err           <= 1'b0;
            parity_err          <= 1'b0;
            right_arrow_pressed <= 1'b0;
            left_arrow_pressed  <= 1'b0;
            enter_pressed       <= 1'b0;
            botoes              <= '0;
            hold_cnt            <= '0;
        end else begin
            byte_valid          <= accept_c;
            frame_err           <= frame_err_c;
            parity_err          <= parity_err_c;
            right_arrow_pressed <= accept_c && (shift == CODE_RIGHT);
            left_arrow_pressed  <= accept_c && (shift == CODE_LEFT);
            enter_pressed       <= accept_c && ((shift == CODE_ENTER) || (shift == CODE_CR));
            if (accept_c)
                rx_byte <= shift;
            if (accept_c && is_note_c) begin
                botoes   <= NOTE_COUNT'(1) << note_idx_c;
                hold_cnt <= HOLD_W'(HOLD_CYCLES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_W'(1))
                    botoes <= '0;
            end
        end
    end

endmodule
